// File: rtl/snake_input_conditioner_if.sv
// Button/event bundle between the raw push-buttons and the game controller.
// slave: conditioner side (buttons in, events out); master: driver side.
interface snake_input_conditioner_if;
    logic       btn_up_raw;
    logic       btn_down_raw;
    logic       btn_left_raw;
    logic       btn_right_raw;
    logic       sw_start_pause_raw;
    logic       sw_reset_raw;
    logic [1:0] direction_out;
    logic       direction_valid_out;
    logic       start_pause_event_out;
    logic       reset_event_out;

    modport master (
        output btn_up_raw,
        output btn_down_raw,
        output btn_left_raw,
        output btn_right_raw,
        output sw_start_pause_raw,
        output sw_reset_raw,
        input  direction_out,
        input  direction_valid_out,
        input  start_pause_event_out,
        input  reset_event_out
    );

    modport slave (
        input  btn_up_raw,
        input  btn_down_raw,
        input  btn_left_raw,
        input  btn_right_raw,
        input  sw_start_pause_raw,
        input  sw_reset_raw,
        output direction_out,
        output direction_valid_out,
        output start_pause_event_out,
        output reset_event_out
    );
endinterface

// File: rtl/snake_input_conditioner.sv
// Synchronise, debounce and press-detect six buttons; emit direction strobe,
// start/pause and reset pulses. Ports: clk, reset_n (async low), bus (slave).
module snake_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
    parameter int unsigned CNT_W           = 21
) (
    input  logic                     clk,
    input  logic                     reset_n,
    snake_input_conditioner_if.slave bus
);
    localparam int unsigned NCH = 6;
    localparam int unsigned CH_UP    = 0;
    localparam int unsigned CH_DOWN  = 1;
    localparam int unsigned CH_LEFT  = 2;
    localparam int unsigned CH_RIGHT = 3;
    localparam int unsigned CH_SP    = 4;
    localparam int unsigned CH_RST   = 5;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    logic [NCH-1:0]   raw;
    logic [NCH-1:0]   s1_q;
    logic [NCH-1:0]   s2_q;
    logic [NCH-1:0]   st_q;
    logic [NCH-1:0]   st_d;
    logic [NCH-1:0]   prev_q;
    logic [NCH-1:0]   rise;
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];

    logic [1:0] dir_q;
    logic [1:0] dir_d;
    logic       dir_vld_q;
    logic       dir_vld_d;
    logic       sp_evt_q;
    logic       rst_evt_q;

    assign raw = {
        bus.sw_reset_raw,
        bus.sw_start_pause_raw,
        bus.btn_right_raw,
        bus.btn_left_raw,
        bus.btn_down_raw,
        bus.btn_up_raw
    };

    // Two-flop synchroniser per channel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= raw;
            s2_q <= s1_q;
        end
    end

    // Counter runs only while the synchronised level disagrees with the
    // accepted level; any agreement (bounce back) clears it.
    always_comb begin
        st_d = st_q;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != st_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    st_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            st_q <= st_d;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Press edge detector on the accepted level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= st_q;
        end
    end

    assign rise = st_q & ~prev_q;

    // Lower channel index wins when several directions press together.
    always_comb begin
        dir_d     = dir_q;
        dir_vld_d = 1'b0;
        priority case (1'b1)
            rise[CH_UP]: begin
                dir_d     = DIR_UP;
                dir_vld_d = 1'b1;
            end
            rise[CH_DOWN]: begin
                dir_d     = DIR_DOWN;
                dir_vld_d = 1'b1;
            end
            rise[CH_LEFT]: begin
                dir_d     = DIR_LEFT;
                dir_vld_d = 1'b1;
            end
            rise[CH_RIGHT]: begin
                dir_d     = DIR_RIGHT;
                dir_vld_d = 1'b1;
            end
            default: begin
                dir_d     = dir_q;
                dir_vld_d = 1'b0;
            end
        endcase
    end

    // Heading resets to right, the snake's initial direction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dir_q     <= DIR_RIGHT;
            dir_vld_q <= 1'b0;
            sp_evt_q  <= 1'b0;
            rst_evt_q <= 1'b0;
        end else begin
            dir_q     <= dir_d;
            dir_vld_q <= dir_vld_d;
            sp_evt_q  <= rise[CH_SP];
            rst_evt_q <= rise[CH_RST];
        end
    end

    assign bus.direction_out         = dir_q;
    assign bus.direction_valid_out   = dir_vld_q;
    assign bus.start_pause_event_out = sp_evt_q;
    assign bus.reset_event_out       = rst_evt_q;

endmodule

// File: doc/snake_input_conditioner.md
# snake_input_conditioner

Input conditioning stage that sits between the six raw push-buttons (up, down, left, right, start/pause, game reset) and the game logic controller. Each button is synchronised, debounced and edge-detected. The block emits single-cycle press events: an encoded direction with a valid strobe, a start/pause event and a game-reset event. All logic is in the system clock domain; no outputs are combinational from raw inputs.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 2_000_000: consecutive stable cycles required to accept a level change (20 ms at 100 MHz). Minimum 2.
- CNT_W, 21: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES-1.

Ports:
- clk  in  1  system clock. One clock; reset is asynchronous and active-low.
- reset_n  in  1  asynchronous active-low reset.
- btn_up_raw  in  1  raw button, active-high, asynchronous.
- btn_down_raw  in  1  raw button, active-high, asynchronous.
- btn_left_raw  in  1  raw button, active-high, asynchronous.
- btn_right_raw  in  1  raw button, active-high, asynchronous.
- sw_start_pause_raw  in  1  raw button, active-high, asynchronous.
- sw_reset_raw  in  1  raw button, active-high, asynchronous.
- direction_out  out  2  last accepted direction: 00 up, 01 down, 10 left, 11 right.
- direction_valid_out  out  1  one-cycle strobe; direction_out is updated in the same cycle.
- start_pause_event_out  out  1  one-cycle press pulse.
- reset_event_out  out  1  one-cycle press pulse.

## Operation
- Each of the six channels has an identical pipeline: a 2-FF synchroniser (s1, s2), then a debounce counter cnt[CNT_W-1:0] with a stable level st, then a rising-edge detector.
- Debounce, per clock edge:
  - If s2 == st: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: st <= s2 and cnt <= 0.
  - Else: cnt <= cnt+1.
- Any bounce back to the old level before the count completes clears cnt. Glitches shorter than DEBOUNCE_CYCLES cycles never change st.
- Release is debounced with the same rule. Only rising edges of st (press) produce events; falling edges produce nothing.
- Press pulse: registered, high for exactly one cycle after st goes 0→1. A held button produces one pulse only, with no auto-repeat.
- Direction encoding, registered:
  - If any direction press pulse occurs, direction_valid_out <= 1 and direction_out <= encoding of the highest-priority pressed button.
  - Fixed priority: up > down > left > right.
  - Otherwise direction_valid_out <= 0 and direction_out holds its value.
- The block does no opposite-direction filtering; the game logic controller owns reversal rejection.
- start_pause_event_out and reset_event_out are independent of the direction path. They may pulse in the same cycle as each other and as direction_valid_out.

## Timing
- Reset (asynchronous assert):
  - All s1, s2, st, cnt and edge registers go to 0.
  - direction_out = 2'b11 (right, the initial snake heading).
  - direction_valid_out, start_pause_event_out and reset_event_out = 0.
- Latency: if raw is first sampled high at edge k and stays high, the event output is high for exactly the cycle following edge k+DEBOUNCE_CYCLES+2.
- Release acceptance takes the same latency. A new press is accepted only after st has returned to 0.
- Reset mid-count discards the pending count.
- A button held through reset release is treated as a fresh press. One pulse follows after the full latency measured from the first post-reset sampling edge.
- Simultaneous direction presses accepted on the same edge yield one strobe at the priority winner. The losing buttons produce no later event while they stay held.
- Back-to-back presses on different direction buttons yield consecutive strobes, each carrying its own encoding.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset: assert reset_n=0 with buttons toggling -> direction_out=11 and all pulses 0 throughout. Release reset with buttons low for 20 cycles -> no pulses.
- Clean press: btn_left_raw rises and is sampled at edge k, then held 50 cycles -> direction_valid_out=1 with direction_out=10 only in the cycle after edge k+6. Then 0, and direction_out stays 10. Release and wait -> no further strobe.
- Bounce rejection: btn_up_raw toggles high 3 cycles, low 1, high 3, low for good -> no strobe, direction_out unchanged. Same pattern then held high -> exactly one strobe with direction_out=00.
- Priority: btn_down_raw and btn_right_raw rise on the same edge -> single strobe with direction_out=01. Release both, press right alone -> strobe with direction_out=11.
- Events: sw_start_pause_raw and sw_reset_raw pressed together with btn_up_raw -> start_pause_event_out, reset_event_out and direction_valid_out all high in the same single cycle.
- Mid-count reset: hold btn_right_raw, assert reset_n for 1 cycle at count 2, keep holding -> no pulse before reset. Exactly one strobe DEBOUNCE_CYCLES+2 edges after the first post-reset sampling edge.
